// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a valid/ready handshake and a 2-entry skid buffer.
// Decodes the immediate, its type, CSR zimm and an illegal-opcode flag; carries a sideband tag.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;

    typedef struct packed {
        logic signed [XLEN-1:0] imm;
        logic [2:0]             typ;
        logic                   ill;
        logic [TAG_W-1:0]       tag;
    } dec_t;

    // Every legal opcode ends in 2'b11, so compressed encodings fall into the default arm.
    function automatic dec_t decode(input logic [31:0] instr, input logic [TAG_W-1:0] tag);
        logic signed [31:0] imm32;
        dec_t d;
        imm32 = '0;
        d.typ = T_NONE;
        d.ill = 1'b0;
        d.tag = tag;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
                d.typ = T_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                d.typ = T_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                d.typ = T_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                d.typ = T_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                d.typ = T_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP: d.typ = T_NONE;
            OPC_SYSTEM: begin
                case (instr[14:12])
                    3'b100: d.ill = 1'b1;
                    3'b101, 3'b110, 3'b111: begin
                        d.typ = T_Z;
                        imm32 = {27'b0, instr[19:15]};
                    end
                    default: begin
                        d.typ = T_I;
                        imm32 = {{20{instr[31]}}, instr[31:20]};
                    end
                endcase
            end
            default: d.ill = 1'b1;
        endcase
        d.imm = XLEN'(imm32);
        return d;
    endfunction

    dec_t dec_p0;
    dec_t main_p1;
    dec_t skid_p1;
    logic vld_p1;
    logic skid_valid;
    logic in_fire;
    logic main_free;

    always_comb begin
        dec_p0 = decode(in_instr, in_tag);
    end

    assign in_ready  = ~skid_valid;
    assign in_fire   = in_valid & in_ready;
    assign main_free = ~vld_p1 | out_ready;

    // p0 -> p1: main register is refilled from the skid first, otherwise from the decoder
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            skid_valid <= 1'b0;
            main_p1    <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_p1    <= skid_p1;
                vld_p1     <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_p1 <= dec_p0;
                vld_p1  <= in_fire;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!main_free && in_fire) begin
            skid_p1 <= dec_p0;
        end
    end

    assign out_valid   = vld_p1;
    assign out_imm     = main_p1.imm;
    assign out_type    = main_p1.typ;
    assign out_illegal = main_p1.ill;
    assign out_tag     = main_p1.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input stream.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [7:0]  in_tag;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [2:0]  out_type;
    logic [7:0]  out_tag;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_type64;
    logic [7:0]  out_tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_type(out_type), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_type(out_type64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    localparam int NV = 21;
    logic [31:0] v_instr [NV] = '{
        32'hFFF00093, 32'hFE20AE23, 32'h123452B7, 32'h800002B7, 32'h3002D073,
        32'h00000000, 32'hFE000EE3, 32'h00000463, 32'h001000EF, 32'hFFFFF06F,
        32'h003100B3, 32'hFFFFF097, 32'h00412083, 32'hFFF08067, 32'h0FF0000F,
        32'h00100073, 32'hC00020F3, 32'h00004073, 32'hFFF00090, 32'h0000001B,
        32'h300FF073};
    logic [63:0] v_imm [NV] = '{
        64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'h00000000_12345000, 64'hFFFFFFFF_80000000,
        64'h5, 64'h0, 64'hFFFFFFFF_FFFFFFFC, 64'h8, 64'h800, 64'hFFFFFFFF_FFFFFFFE,
        64'h0, 64'hFFFFFFFF_FFFFF000, 64'h4, 64'hFFFFFFFF_FFFFFFFF, 64'hFF,
        64'h1, 64'hFFFFFFFF_FFFFFC00, 64'h0, 64'h0, 64'h0, 64'h1F};
    logic [2:0] v_typ [NV] = '{
        3'd1, 3'd2, 3'd4, 3'd4, 3'd6, 3'd0, 3'd3, 3'd3, 3'd5, 3'd5,
        3'd0, 3'd4, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd6};
    logic v_ill [NV] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    typedef struct {
        logic [7:0]  tag;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e, p;
    int   cur_idx;
    int   checks = 0;
    int   failures = 0;
    logic running;
    logic prev_stall, prev_free;
    logic [127:0] snap;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] outs_now();
        return {out_valid, out_tag, out_type, out_illegal, out_imm, out_imm64};
    endfunction

    // Monitor first, then record new input fires; the whole bench drives at posedge+1.
    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            q64.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q32.size() == 0) chk("out32_unexpected", 1, 0);
                else begin
                    e = q32.pop_front();
                    chk("out32", {out_tag, out_type, out_illegal, out_imm},
                        {e.tag, e.typ, e.ill, e.imm[31:0]});
                end
            end
            if (out_valid64 && out_ready) begin
                if (q64.size() == 0) chk("out64_unexpected", 1, 0);
                else begin
                    e = q64.pop_front();
                    chk("out64", {out_tag64, out_type64, out_illegal64, out_imm64},
                        {e.tag, e.typ, e.ill, e.imm});
                end
            end
            if (prev_stall) chk("stable_during_stall", outs_now(), snap);
            if (prev_free) chk("in_ready_when_skid_empty", {in_ready, in_ready64}, 2'b11);
            p.tag = in_tag;
            p.imm = v_imm[cur_idx];
            p.typ = v_typ[cur_idx];
            p.ill = v_ill[cur_idx];
            if (in_valid && in_ready) q32.push_back(p);
            if (in_valid && in_ready64) q64.push_back(p);
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_free  = rst_n && (!out_valid || out_ready);
        snap = outs_now();
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int idx, input logic [7:0] tag);
        int n;
        n = 0;
        cur_idx  = idx;
        in_instr = v_instr[idx];
        in_tag   = tag;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic lat_send(input int idx, input logic [7:0] tag);
        send(idx, tag);
        @(negedge clk);
        chk("latency_1cycle", {out_valid, out_tag}, {1'b1, tag});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((q32.size() != 0 || q64.size() != 0 || out_valid) && n < 100) begin
            n++;
            @(posedge clk);
        end
        #1;
        if (n >= 100) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0;
        out_ready = 1'b1; cur_idx = 0; running = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset32", {out_valid, in_ready, out_imm, out_type, out_illegal, out_tag},
            {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 8'h0});
        chk("reset64", {out_valid64, in_ready64, out_imm64, out_type64, out_illegal64, out_tag64},
            {1'b0, 1'b1, 64'h0, 3'd0, 1'b0, 8'h0});
        @(posedge clk);
        #1 rst_n = 1'b1;

        lat_send(0, 8'hA1);
        for (int i = 0; i < NV; i++) send(i, 8'h10 + 8'(i));
        drain();

        // Backpressure: tag1 in main, tag2 in skid, tag3 held off
        out_ready = 1'b0;
        send(2, 8'd1);
        send(4, 8'd2);
        cur_idx = 6; in_instr = v_instr[6]; in_tag = 8'd3; in_valid = 1'b1;
        @(negedge clk);
        chk("full_in_ready_low", in_ready, 0);
        chk("stall_holds_tag1", {out_valid, out_tag}, {1'b1, 8'd1});
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_in_ready_still_low", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        nv = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (out_valid) nv++;
            @(posedge clk); #1;
            if (k == 1) in_valid = 1'b0;
        end
        chk("no_gap_after_release", nv, 3);
        drain();

        running = 1'b1;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(k % NV, 8'(k));
                end
                running = 1'b0;
            end
            begin
                while (running) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Reset with main and skid both occupied
        out_ready = 1'b0;
        send(0, 8'h55);
        send(1, 8'h66);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midflight_reset32", {out_valid, in_ready, out_imm, out_type, out_illegal, out_tag},
            {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 8'h0});
        chk("midflight_reset64", {out_valid64, in_ready64, out_imm64, out_type64, out_illegal64, out_tag64},
            {1'b0, 1'b1, 64'h0, 3'd0, 1'b0, 8'h0});
        @(posedge clk); #1;
        lat_send(2, 8'h77);
        drain();
        repeat (2) @(posedge clk);
        chk("q32_empty", q32.size(), 0);
        chk("q64_empty", q64.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
